// File: rtl/ecl_pkg.sv
// Shared definitions for the ECL counter-slice sequencer family.
package ecl_pkg;

    // Mode select driven onto the shared S1/S0 pins of every mc10136 slice.
    typedef enum logic [1:0] {
        LOAD = 2'b00,
        DEC  = 2'b01,
        INC  = 2'b10,
        HOLD = 2'b11
    } tCounterMode;

    // Controller states of loop_count_seq.
    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_LOAD = 2'b10,
        ST_RUN  = 2'b11
    } tSeqState;

endpackage

// File: rtl/loop_count_seq_if.sv
// Request/status bundle between a loop-count client and loop_count_seq.
interface loop_count_seq_if #(
    parameter int SLICES = 3
);
    localparam int W = 4 * SLICES;

    logic         start;
    logic [W-1:0] count;
    logic         pause;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] remaining;

    modport master (
        output start, count, pause, abort,
        input  busy, done, remaining
    );

    modport slave (
        input  start, count, pause, abort,
        output busy, done, remaining
    );
endinterface

// File: rtl/mc10136.sv
// Behavioural model of one mc10136 universal hex counter slice.
// Counting is enabled by an active-low carry/borrow in; nCO goes low when the
// slice is enabled and sits at its terminal value for the selected direction.
module mc10136
    import ecl_pkg::*;
(
    input  logic        clk,
    input  tCounterMode mode_i,
    input  logic [3:0]  d_i,
    input  logic        nci_i,
    output logic [3:0]  q_o,
    output logic        nco_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next slice value from the mode pins and carry-in.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        q_d = q_q;
        unique case (mode_i)
            LOAD:    q_d = d_i;
            DEC:     if (!nci_i) q_d = q_q - 4'd1;
            INC:     if (!nci_i) q_d = q_q + 4'd1;
            default: q_d = q_q;
        endcase
    end

    // Slice register; the real part has no reset pin, the controller clears it.
    // NOTE: no reset here on purpose -- the contents are defined by an explicit LOAD cycle, and non-blocking assignment keeps all slices updating from the same pre-edge values.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    // Active-low carry/borrow out, combinational from mode, Q and carry-in.
    always_comb begin
        nco_o = 1'b1;
        if (!nci_i) begin
            if (mode_i == DEC && q_q == 4'h0) nco_o = 1'b0;
            if (mode_i == INC && q_q == 4'hF) nco_o = 1'b0;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/loop_count_seq.sv
// Loop/step counter sequencer: loads a cascaded mc10136 chain with a count,
// decrements it once per clock (honouring pause), and pulses done at zero.
module loop_count_seq
    import ecl_pkg::*;
#(
    parameter int SLICES = 3
) (
    input  logic            clk,
    input  logic            nreset,
    loop_count_seq_if.slave bus
);

    localparam int W = 4 * SLICES;

    tSeqState     state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;
    logic         zero_req_q, zero_req_d;

    tCounterMode     mode;
    logic [W-1:0]    load_data;
    logic [W-1:0]    chain_val;
    logic [SLICES-1:0] nco;
    logic            chain_nz;
    logic            unused_top_nco;

    // Slice chain: shared mode, ripple borrow from slice k-1 nCO into slice k nCI.
    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        logic nci;
        if (k == 0) begin : g_first
            assign nci = 1'b0;
        end else begin : g_rest
            assign nci = nco[k-1];
        end
        mc10136 u_slice (
            .clk    (clk),
            .mode_i (mode),
            .d_i    (load_data[4*k +: 4]),
            .nci_i  (nci),
            .q_o    (chain_val[4*k +: 4]),
            .nco_o  (nco[k])
        );
    end

    // The top slice borrow is not used: zero is detected on Q to avoid a mode->nCO->mode loop.
    assign unused_top_nco = nco[SLICES-1];
    assign chain_nz       = |chain_val;

    // Next-state, slice mode/data and done request.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        zero_req_d = 1'b0;
        mode       = HOLD;
        load_data  = '0;
        unique case (state_q)
            ST_INIT: begin
                // Slices power up with garbage; clear them once.
                mode    = LOAD;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                done_d = zero_req_q;
                if (bus.start) begin
                    if (bus.count != '0) begin
                        count_d = bus.count;
                        state_d = ST_LOAD;
                    end else begin
                        // Zero count completes one clock later without loading.
                        zero_req_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mode      = LOAD;
                    load_data = count_q;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!chain_nz) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (!bus.pause) begin
                    mode = DEC;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_INIT;
            count_q    <= '0;
            done_q     <= 1'b0;
            zero_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            zero_req_q <= zero_req_d;
        end
    end

    assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign bus.done      = done_q;
    assign bus.remaining = (state_q == ST_INIT) ? '0 : chain_val;

endmodule
